// File: rtl/sparse_mem_loader_if.sv
// Dense input stream plus memory write port of the sparse memory loader.
// The loader side uses the slave modport, the upstream/memory side uses master.
interface sparse_mem_loader_if #(
    parameter int BUS_SIZE  = 32,
    parameter int MEM_SIZE  = 128,
    parameter int CHUNK_NUM = 16
);
    localparam int BEAT_NUM = MEM_SIZE / BUS_SIZE;
    localparam int DW       = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
    localparam int CW       = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;

    logic                  in_valid;
    logic [BUS_SIZE*8-1:0] in_data;
    logic                  in_ready;
    logic                  wr_valid;
    logic [BUS_SIZE-1:0]   wr_sparsemap;
    logic [BUS_SIZE*8-1:0] wr_nonzero_data;
    logic [DW-1:0]         wr_dat_count;
    logic [CW-1:0]         wr_chunk_count;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_valid, wr_sparsemap, wr_nonzero_data,
               wr_dat_count, wr_chunk_count
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_valid, wr_sparsemap, wr_nonzero_data,
               wr_dat_count, wr_chunk_count
    );
endinterface

// File: rtl/sparse_mem_loader.sv
// Converts a dense byte stream into sparsemap + left-packed non-zero bytes and
// writes them to an SRAM chunk range, tagging each beat with its beat/chunk index.
module sparse_mem_loader #(
    parameter int BUS_SIZE  = 32,
    parameter int MEM_SIZE  = 128,
    parameter int CHUNK_NUM = 16,
    localparam int BEAT_NUM = MEM_SIZE / BUS_SIZE,
    localparam int DW       = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1,
    localparam int CW       = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [CW-1:0]       chunk_base_i,
    input  logic [CW:0]         chunk_cnt_i,
    sparse_mem_loader_if.slave  mem_if,
    output logic                busy_o,
    output logic                done_o
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    state_e                state_q, state_d;
    logic [DW-1:0]         dat_q, dat_d;
    logic [CW-1:0]         chunk_q, chunk_d;
    logic [CW:0]           remain_q, remain_d;
    logic                  accept;

    logic                  vld_p1_q, vld_p1_d;
    logic [BUS_SIZE*8-1:0] data_p1_q, data_p1_d;
    logic [BUS_SIZE-1:0]   map_p1_q, map_p1_d;
    logic [DW-1:0]         dat_p1_q, dat_p1_d;
    logic [CW-1:0]         chunk_p1_q, chunk_p1_d;

    logic                  vld_p2_q, vld_p2_d;
    logic [BUS_SIZE*8-1:0] pk_p2_q, pk_p2_d;
    logic [BUS_SIZE-1:0]   map_p2_q, map_p2_d;
    logic [DW-1:0]         dat_p2_q, dat_p2_d;
    logic [CW-1:0]         chunk_p2_q, chunk_p2_d;

    function automatic logic [BUS_SIZE-1:0] sparsemap(input logic [BUS_SIZE*8-1:0] data);
        logic [BUS_SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            m[i] = |data[8*i +: 8];
        end
        return m;
    endfunction

    function automatic logic [BUS_SIZE*8-1:0] pack_nonzero(input logic [BUS_SIZE*8-1:0] data,
                                                            input logic [BUS_SIZE-1:0]   map);
        logic [BUS_SIZE*8-1:0] res;
        int                    k;
        res = '0;
        k   = 0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            if (map[i]) begin
                res[8*k +: 8] = data[8*i +: 8];
                k             = k + 1;
            end
        end
        return res;
    endfunction

    assign accept = (state_q == RUN) && mem_if.in_valid;

    always_comb begin
        state_d  = state_q;
        dat_d    = dat_q;
        chunk_d  = chunk_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: begin
                if (start_i && (chunk_cnt_i != '0)) begin
                    chunk_d  = chunk_base_i;
                    remain_d = chunk_cnt_i;
                    dat_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (dat_q == DW'(BEAT_NUM - 1)) begin
                        dat_d    = '0;
                        // Chunk address wraps modulo the memory depth, not the counter width.
                        chunk_d  = (chunk_q == CW'(CHUNK_NUM - 1)) ? '0 : chunk_q + CW'(1);
                        remain_d = remain_q - (CW+1)'(1);
                        if (remain_q == (CW+1)'(1)) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        dat_d = dat_q + DW'(1);
                    end
                end
            end
            FLUSH: begin
                if (!vld_p1_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            dat_q    <= '0;
            chunk_q  <= '0;
            remain_q <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dat_q    <= dat_d;
            chunk_q  <= chunk_d;
            remain_q <= remain_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // Stage 1: raw beat, its sparsemap and the counters at acceptance
    always_comb begin
        vld_p1_d   = accept;
        data_p1_d  = mem_if.in_data;
        map_p1_d   = sparsemap(mem_if.in_data);
        dat_p1_d   = dat_q;
        chunk_p1_d = chunk_q;
    end

    // Stage 2: compacted data with tags, drives the write port
    always_comb begin
        vld_p2_d   = vld_p1_q;
        pk_p2_d    = pack_nonzero(data_p1_q, map_p1_q);
        map_p2_d   = map_p1_q;
        dat_p2_d   = dat_p1_q;
        chunk_p2_d = chunk_p1_q;
    end

    always_ff @(posedge clk_i) begin
        data_p1_q  <= data_p1_d;
        map_p1_q   <= map_p1_d;
        dat_p1_q   <= dat_p1_d;
        chunk_p1_q <= chunk_p1_d;
        pk_p2_q    <= pk_p2_d;
        map_p2_q   <= map_p2_d;
        dat_p2_q   <= dat_p2_d;
        chunk_p2_q <= chunk_p2_d;
    end

    // Data registers are not reset, so the write bus is qualified by the valid bit.
    assign mem_if.in_ready        = (state_q == RUN);
    assign mem_if.wr_valid        = vld_p2_q;
    assign mem_if.wr_sparsemap    = vld_p2_q ? map_p2_q   : '0;
    assign mem_if.wr_nonzero_data = vld_p2_q ? pk_p2_q    : '0;
    assign mem_if.wr_dat_count    = vld_p2_q ? dat_p2_q   : '0;
    assign mem_if.wr_chunk_count  = vld_p2_q ? chunk_p2_q : '0;
    assign busy_o                 = (state_q != IDLE);
    assign done_o                 = (state_q == DONE);
endmodule

// File: tb/tb_sparse_mem_loader.sv
// Directed, table-driven bench for sparse_mem_loader with hand-computed expectations.
module tb_sparse_mem_loader;
    typedef struct {
        logic [255:0] data;
        logic [31:0]  map;
        logic [255:0] pk;
        logic [1:0]   dat;
        logic [3:0]   chunk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base = '0;
    logic [4:0] cnt = '0;
    logic       busy;
    logic       done;
    int         n_vec = 0;
    int         n_bad = 0;
    vec_t       tbl[8];

    sparse_mem_loader_if #(.BUS_SIZE(32), .MEM_SIZE(128), .CHUNK_NUM(16)) bus ();

    sparse_mem_loader #(.BUS_SIZE(32), .MEM_SIZE(128), .CHUNK_NUM(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .chunk_base_i (base),
        .chunk_cnt_i  (cnt),
        .mem_if       (bus),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] b, input logic [4:0] c);
        start = 1'b1;
        base  = b;
        cnt   = c;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [4:0] vp;
        int         ex_dat;

        tbl[0] = '{data: (256'hFF << 248) | (256'hA0 << 24) | 256'h05, map: 32'h80000009,
                   pk: 256'hFFA005, dat: 2'd0, chunk: 4'd15};
        tbl[1] = '{data: 256'h0, map: 32'h0, pk: 256'h0, dat: 2'd1, chunk: 4'd15};
        tbl[2] = '{data: {32{8'h01}}, map: 32'hFFFFFFFF, pk: {32{8'h01}}, dat: 2'd2, chunk: 4'd15};
        tbl[3] = '{data: (256'h56 << 240) | (256'h34 << 16) | (256'h12 << 8), map: 32'h40000006,
                   pk: 256'h563412, dat: 2'd3, chunk: 4'd15};
        tbl[4] = '{data: 256'h80 << 248, map: 32'h80000000, pk: 256'h80, dat: 2'd0, chunk: 4'd0};
        tbl[5] = '{data: 256'h7F, map: 32'h00000001, pk: 256'h7F, dat: 2'd1, chunk: 4'd0};
        tbl[6] = '{data: {16{16'h00AA}}, map: 32'h55555555, pk: {128'h0, {16{8'hAA}}},
                   dat: 2'd2, chunk: 4'd0};
        tbl[7] = '{data: {16{16'hBB00}}, map: 32'hAAAAAAAA, pk: {128'h0, {16{8'hBB}}},
                   dat: 2'd3, chunk: 4'd0};

        // Reset defaults with in_valid asserted throughout
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_wr_valid", bus.wr_valid, 0);
        chk("rst_map", bus.wr_sparsemap, 0);
        chk("rst_data", bus.wr_nonzero_data, 0);
        chk("rst_dat", bus.wr_dat_count, 0);
        chk("rst_chunk", bus.wr_chunk_count, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("idle_wr_valid", bus.wr_valid, 0);
            chk("idle_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;

        // Table load: base 15, two chunks, wraps to chunk 0
        do_start(4'd15, 5'd2);
        chk("tbl_ready_rise", bus.in_ready, 1);
        chk("tbl_busy", busy, 1);
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                bus.in_valid = 1'b1;
                bus.in_data  = tbl[j].data;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
            tick();
            if (j >= 1 && j <= 8) begin
                chk("tbl_wr_valid", bus.wr_valid, 1);
                chk("tbl_map", bus.wr_sparsemap, tbl[j-1].map);
                chk("tbl_data", bus.wr_nonzero_data, tbl[j-1].pk);
                chk("tbl_dat", bus.wr_dat_count, tbl[j-1].dat);
                chk("tbl_chunk", bus.wr_chunk_count, tbl[j-1].chunk);
            end
            chk("tbl_ready", bus.in_ready, (j < 7) ? 1 : 0);
            chk("tbl_done", done, (j == 9) ? 1 : 0);
            if (j == 9) begin
                chk("tbl_last_gap", bus.wr_valid, 0);
                chk("tbl_busy_done", busy, 1);
            end
        end
        // start coinciding with done must be ignored
        start = 1'b1;
        base  = 4'd0;
        cnt   = 5'd1;
        tick();
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        tick();
        chk("start_on_done_ready", bus.in_ready, 0);
        chk("start_on_done_busy", busy, 0);

        // Full chunk stream, base 2, with a stray start during RUN
        do_start(4'd2, 5'd2);
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                bus.in_valid = 1'b1;
                bus.in_data  = {32{8'(j + 1)}};
            end else begin
                bus.in_valid = 1'b0;
            end
            if (j == 2) begin
                start = 1'b1;
                base  = 4'd9;
                cnt   = 5'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (j >= 1 && j <= 8) begin
                chk("full_wr_valid", bus.wr_valid, 1);
                chk("full_dat", bus.wr_dat_count, (j - 1) % 4);
                chk("full_chunk", bus.wr_chunk_count, 2 + (j - 1) / 4);
                chk("full_map", bus.wr_sparsemap, 32'hFFFFFFFF);
                chk("full_data", bus.wr_nonzero_data, {32{8'(j)}});
            end
            if (j == 7) chk("full_ready_low", bus.in_ready, 0);
            if (j == 8) chk("full_done_early", done, 0);
            if (j == 9) chk("full_done", done, 1);
        end
        tick();
        chk("full_idle", busy, 0);

        // Gaps in in_valid propagate as gaps in wr_valid
        do_start(4'd5, 5'd1);
        vp     = 5'b11101;
        ex_dat = 0;
        for (int j = 0; j < 8; j++) begin
            bus.in_valid = (j < 5) ? vp[j] : 1'b0;
            bus.in_data  = {32{8'(j + 16)}};
            tick();
            if (j >= 1 && j <= 5) begin
                chk("gap_wr_valid", bus.wr_valid, vp[j-1]);
                if (vp[j-1]) begin
                    chk("gap_dat", bus.wr_dat_count, ex_dat);
                    chk("gap_chunk", bus.wr_chunk_count, 5);
                    chk("gap_data", bus.wr_nonzero_data, {32{8'(j + 15)}});
                    ex_dat++;
                end
            end
            if (j == 5) chk("gap_done_early", done, 0);
            if (j == 6) chk("gap_done", done, 1);
        end

        // chunk_cnt 0 leaves the block idle
        start = 1'b1;
        base  = 4'd3;
        cnt   = 5'd0;
        tick();
        start = 1'b0;
        chk("cnt0_busy", busy, 0);
        chk("cnt0_ready", bus.in_ready, 0);
        tick();
        chk("cnt0_busy2", busy, 0);

        // Reset after three of four beats aborts the load
        do_start(4'd3, 5'd1);
        for (int j = 0; j < 3; j++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {32{8'h22}};
            tick();
        end
        chk("abort_pre_valid", bus.wr_valid, 1);
        rst = 1'b1;
        tick();
        chk("abort_wr_valid", bus.wr_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", bus.in_ready, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) begin
            tick();
            chk("abort_no_done", done, 0);
            chk("abort_no_wr", bus.wr_valid, 0);
        end
        do_start(4'd1, 5'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = {32{8'h33}};
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("restart_wr_valid", bus.wr_valid, 1);
        chk("restart_dat", bus.wr_dat_count, 0);
        chk("restart_chunk", bus.wr_chunk_count, 1);
        chk("restart_map", bus.wr_sparsemap, 32'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sparse_mem_loader.md
# sparse_mem_loader

Upstream write stage for the IFM and filter SRAMs of the compute-cluster memory wrapper. It accepts a dense byte stream, one `BUS_SIZE`-byte beat per handshake. For each beat it produces the sparsemap (one bit per byte, set when the byte is non-zero) and the left-packed non-zero data. It drives these onto the memory write port together with the beat (`dat`) and chunk counters. One instance feeds the IFM memory and one feeds the filter memory, each with `CHUNK_NUM` set to that memory's chunk depth.

## Interface
Parameters:
- `BUS_SIZE`, 32, bytes per beat.
- `MEM_SIZE`, 128, bytes per SRAM chunk; must be a multiple of `BUS_SIZE`.
- `CHUNK_NUM`, 16, number of addressable chunks in the target memory.
- Derived: `BEAT_NUM` = `MEM_SIZE/BUS_SIZE`; `DW` = $clog2(`BEAT_NUM`); `CW` = $clog2(`CHUNK_NUM`).

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  start a load; sampled in IDLE only.
- `chunk_base_i`  in  CW  first chunk index, sampled with `start_i`.
- `chunk_cnt_i`  in  CW+1  number of chunks to load, 1..`CHUNK_NUM`; a value of 0 means `start_i` is ignored.
- `in_valid_i`  in  1  dense beat valid.
- `in_data_i`  in  BUS_SIZE*8  dense bytes; byte i is [8i+7:8i].
- `in_ready_o`  out  1  beat accepted when `in_valid_i` && `in_ready_o`.
- `wr_valid_o`  out  1  memory write strobe.
- `wr_sparsemap_o`  out  BUS_SIZE  bit i = (byte i != 0).
- `wr_nonzero_data_o`  out  BUS_SIZE*8  packed non-zero bytes.
- `wr_dat_count_o`  out  DW  beat index within the chunk.
- `wr_chunk_count_o`  out  CW  chunk index.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle pulse when the load is complete.

## Operation
State machine:
- **IDLE**: `start_i` with `chunk_cnt_i` != 0 latches the base chunk and the chunk count, clears the beat counter, and moves to RUN.
- **RUN**: `in_ready_o` = 1 and beats are accepted.
  - The beat counter increments on each accepted beat and wraps from `BEAT_NUM`-1 to 0.
  - On that wrap, the chunk index increments modulo `CHUNK_NUM` (the address wraps, e.g. base 15 → 15, 0, 1) and the remaining-chunk count decrements.
  - Acceptance of the last beat of the last chunk moves the state to FLUSH.
- **FLUSH**: `in_ready_o` = 0. The state is held until the pipeline is empty (2 cycles), then moves to DONE.
- **DONE**: `done_o` = 1 for one cycle, then the state returns to IDLE.

Pipeline:
- **Stage 1**: registers the input beat, its sparsemap, and the counter values tagged to that beat.
- **Stage 2**: registers the compacted data and the tags, and drives all `wr_*` outputs.

Packing rules:
- The k-th non-zero byte, counted in ascending lane order, is placed in output lane k.
- Lanes at or above popcount(sparsemap) are 0.
- An all-zero beat is still written: sparsemap 0, data 0.

Other rules:
- `wr_dat_count_o` and `wr_chunk_count_o` are the counter values at the moment that beat was accepted, not the current counters.
- `start_i` outside IDLE is ignored.
- `in_valid_i` outside RUN is ignored; nothing is accepted.
- The memory write port has no backpressure; `wr_valid_o` is never stalled.

## Timing
- Reset: every output is 0, the state is IDLE, and both pipeline stages are invalid. A reset asserted mid-load aborts it:
  - no `wr_valid_o` in the cycle after the reset edge;
  - no `done_o`;
  - counters return to 0.
- `in_ready_o` rises the cycle after `start_i` is sampled in IDLE.
- Latency: a beat accepted at cycle t appears with `wr_valid_o` at t+2. Gaps in `in_valid_i` produce matching gaps in `wr_valid_o`.
- Throughput: one beat per cycle.
- `done_o` is asserted the cycle after the final `wr_valid_o`, i.e. 3 cycles after the last beat is accepted.
- `busy_o` falls together with `done_o` deasserting: in the IDLE cycle after DONE.
- `start_i` in the same cycle as `done_o` is ignored; a new start is accepted no earlier than the following cycle.

## Test plan
- **Reset defaults**: reset held for 3 cycles → all outputs 0; pulsing `in_valid_i` gives no `wr_valid_o`.
- **Packing**: base 0, count 1, beat with byte0=0x05, byte3=0xA0, byte31=0xFF, all others 0 → at t+2:
  - `wr_sparsemap_o` = 0x80000009;
  - data lanes 0/1/2 = 0x05/0xA0/0xFF, other lanes 0;
  - `dat` = 0, `chunk` = 0.
- **Full chunk stream**: base 2, count 2, 8 back-to-back beats →
  - `wr_dat_count_o` = 0,1,2,3,0,1,2,3;
  - `wr_chunk_count_o` = 2,2,2,2,3,3,3,3;
  - `in_ready_o` low after the 8th beat;
  - `done_o` 3 cycles after the 8th beat is accepted.
- **Chunk wrap and edge data**: base 15, count 2 →
  - chunk indices 15 then 0;
  - an all-zero beat is written with sparsemap 0;
  - an all-0x01 beat gives sparsemap 0xFFFFFFFF and data unchanged.
- **Gaps and ignored starts**:
  - `in_valid_i` toggled 1,0,1 → `wr_valid_o` 1,0,1 delayed by 2 cycles;
  - `start_i` during RUN has no effect;
  - `chunk_cnt_i` = 0 leaves the block in IDLE.
- **Reset mid-load**: reset after 3 of 4 beats → no `done_o`, `wr_valid_o` 0 from the cycle after the reset edge, `busy_o` 0. A fresh start then begins again at `dat` 0.
